wishbone_rr_arbiter_n: RTL

- N-master to one-slave Wishbone arbiter and interconnect mux. It is the parametrised successor of the fixed two-master data/fetch priority arbiter and mux.
- Sits between the core's memory-side masters (data adapter, icache, future DMA/debug masters) and the external Wishbone bus.
- Adds N channels, a selectable fixed-priority or round-robin mode, a registered grant held for the whole bus cycle, and an optional bus-timeout watchdog.

---
 rtl/wishbone_rr_arbiter_n.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/wishbone_rr_arbiter_n.sv
// N-master to one-slave Wishbone arbiter/mux with fixed-priority or round-robin selection.
// Define WB_ARB_TIMEOUT_EN to add a per-grant watchdog that errors a stalled strobe after TIMEOUT cycles.
module wishbone_rr_arbiter_n #(
    parameter int N       = 2,
    parameter int DW      = 16,
    parameter int AW      = 24,
    parameter int SW      = 2,
    parameter int MODE    = 0,
    parameter int TIMEOUT = 255
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [N-1:0]    i_m_cyc,
    input  logic [N-1:0]    i_m_stb,
    input  logic [N-1:0]    i_m_we,
    input  logic [N*AW-1:0] i_m_adr,
    input  logic [N*DW-1:0] i_m_dat,
    input  logic [N*SW-1:0] i_m_sel,
    output logic [N-1:0]    o_m_ack,
    output logic [N-1:0]    o_m_err,
    output logic [N-1:0]    o_m_rty,
    output logic            o_wb_cyc,
    output logic            o_wb_stb,
    output logic            o_wb_we,
    output logic [AW-1:0]   o_wb_adr,
    output logic [DW-1:0]   o_wb_dat,
    output logic [SW-1:0]   o_wb_sel,
    input  logic            i_wb_ack,
    input  logic            i_wb_err,
    input  logic            i_wb_rty,
    output logic [N-1:0]    o_grant,
    output logic            o_busy
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t        state_r, state_s;
    logic [N-1:0]  grant_r, grant_s;
    logic [IW-1:0] ptr_r, ptr_s;
    logic [IW-1:0] owner_s;
    logic [IW-1:0] winner_s;
    int            rr_idx_s;
    logic          timeout_s;

    // Owner index decoded from the one-hot grant register.
    always_comb begin
        owner_s = '0;
        for (int k = 0; k < N; k++) begin
            owner_s = owner_s | (grant_r[k] ? IW'(k) : '0);
        end
    end

    // Winner selection; descending scan so the first match in priority order sticks.
    always_comb begin
        winner_s = '0;
        rr_idx_s = 0;
        if (MODE == 1) begin
            for (int i = N; i >= 1; i--) begin
                rr_idx_s = (int'(ptr_r) + i) % N;
                winner_s = i_m_cyc[rr_idx_s] ? IW'(rr_idx_s) : winner_s;
            end
        end else begin
            for (int k = N - 1; k >= 0; k--) begin
                winner_s = i_m_cyc[k] ? IW'(k) : winner_s;
            end
        end
    end

    // Next-state logic: grant is locked until the owner releases cyc.
    always_comb begin
        state_s = state_r;
        grant_s = grant_r;
        ptr_s   = ptr_r;
        case (state_r)
            IDLE: begin
                if (|i_m_cyc) begin
                    state_s = GRANT;
                    grant_s = N'(1) << winner_s;
                    ptr_s   = winner_s;
                end else begin
                    state_s = IDLE;
                end
            end
            GRANT: begin
                if (!i_m_cyc[owner_s]) begin
                    state_s = IDLE;
                    grant_s = '0;
                end else begin
                    state_s = GRANT;
                end
            end
            default: begin
                state_s = IDLE;
                grant_s = '0;
            end
        endcase
    end

    // State, grant and round-robin pointer registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r <= IDLE;
            grant_r <= '0;
            ptr_r   <= IW'(N - 1);
        end else begin
            state_r <= state_s;
            grant_r <= grant_s;
            ptr_r   <= ptr_s;
        end
    end

`ifdef WB_ARB_TIMEOUT_EN
    logic [7:0] tmo_cnt_r;

    assign timeout_s = (state_r == GRANT) && i_m_stb[owner_s] && (tmo_cnt_r == 8'(TIMEOUT));

    // Watchdog counts unanswered strobe cycles; the forced stb=0 on expiry clears it.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            tmo_cnt_r <= 8'd0;
        end else if ((state_r == GRANT) && o_wb_stb && !(i_wb_ack || i_wb_err || i_wb_rty)) begin
            tmo_cnt_r <= tmo_cnt_r + 8'd1;
        end else begin
            tmo_cnt_r <= 8'd0;
        end
    end
`else
    assign timeout_s = 1'b0;
`endif

    // Slave-side mux and owner-only response routing.
    always_comb begin
        o_wb_cyc = 1'b0;
        o_wb_stb = 1'b0;
        o_wb_we  = 1'b0;
        o_wb_adr = '0;
        o_wb_dat = '0;
        o_wb_sel = '0;
        o_m_ack  = '0;
        o_m_err  = '0;
        o_m_rty  = '0;
        if (state_r == GRANT) begin
            o_wb_cyc = i_m_cyc[owner_s];
            o_wb_stb = i_m_stb[owner_s] & ~timeout_s;
            o_wb_we  = i_m_we[owner_s];
            o_wb_adr = i_m_adr[int'(owner_s) * AW +: AW];
            o_wb_dat = i_m_dat[int'(owner_s) * DW +: DW];
            o_wb_sel = i_m_sel[int'(owner_s) * SW +: SW];
            o_m_ack  = N'(i_wb_ack) << owner_s;
            o_m_err  = N'(i_wb_err | timeout_s) << owner_s;
            o_m_rty  = N'(i_wb_rty) << owner_s;
        end else begin
            o_wb_cyc = 1'b0;
        end
    end

    assign o_grant = grant_r;
    assign o_busy  = (state_r == GRANT);

endmodule
